// File: rtl/logic_basic_gray_counter_pkg.sv
// Shared types and helpers for the Gray-code counter slice: step direction
// encoding and width-generic wrap detection on a zero-extended count word.
package logic_basic_gray_counter_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic gray_word_t width_mask(input int w);
    gray_word_t m;
    m = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // An up step wraps from all-ones, a down step wraps from zero.
  function automatic logic step_wraps(input gray_word_t v, input int w, input dir_e d);
    gray_word_t m;
    m = width_mask(w);
    if (d == DIR_DOWN) return (v & m) == '0;
    return (v & m) == m;
  endfunction

endpackage

// File: rtl/logic_basic_binary2gray.sv
// Combinational binary to reflected-Gray converter; zero latency, no flow control.
module logic_basic_binary2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/logic_basic_gray_counter.sv
// Stream-driven Gray counter: each accepted rx beat steps the count and emits its Gray code one cycle later;
// rx stalls while a tx beat is held. Define LOGIC_BASIC_GRAY_COUNTER_DOWN_EN to add the dir (decrement) input.
module logic_basic_gray_counter
  import logic_basic_gray_counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             rx_tvalid,
  output logic             rx_tready,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic [WIDTH-1:0] tx_tdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap
`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
  ,
  input  logic             dir
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] count_gray_d, count_gray_q;
  logic [WIDTH-1:0] tx_tdata_d, tx_tdata_q;
  logic             tx_tvalid_d, tx_tvalid_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] step_gray;
  logic             step;
  dir_e             step_dir;

`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
  assign step_dir = dir_e'(dir);
`else
  assign step_dir = DIR_UP;
`endif

  // Depends only on control inputs and registered state, never on rx_tvalid.
  assign rx_tready = areset_n & ~clear & ~load & (~tx_tvalid_q | tx_tready);
  assign step      = rx_tvalid & rx_tready;
  assign step_cnt  = (step_dir == DIR_DOWN) ? (count_q - ONE) : (count_q + ONE);

  logic_basic_binary2gray #(.WIDTH(WIDTH)) u_tx_b2g (
    .bin  (step_cnt),
    .gray (step_gray)
  );

  logic_basic_binary2gray #(.WIDTH(WIDTH)) u_cnt_b2g (
    .bin  (count_d),
    .gray (count_gray_d)
  );

  always_comb begin
    count_d     = count_q;
    tx_tvalid_d = tx_tvalid_q;
    tx_tdata_d  = tx_tdata_q;
    wrap_d      = 1'b0;
    if (!areset_n) begin
      count_d = RESET_VALUE;
    end else if (clear) begin
      count_d     = RESET_VALUE;
      tx_tvalid_d = 1'b0;
    end else begin
      if (tx_tvalid_q && tx_tready) tx_tvalid_d = 1'b0;
      if (load) begin
        count_d = load_value;
      end else if (step) begin
        count_d     = step_cnt;
        tx_tvalid_d = 1'b1;
        tx_tdata_d  = step_gray;
        wrap_d      = step_wraps(gray_word_t'(count_q), WIDTH, step_dir);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      count_q      <= RESET_VALUE;
      count_gray_q <= count_gray_d;
      tx_tvalid_q  <= 1'b0;
      tx_tdata_q   <= '0;
      wrap_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      count_gray_q <= count_gray_d;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_tdata_q   <= tx_tdata_d;
      wrap_q       <= wrap_d;
    end
  end

  assign count      = count_q;
  assign count_gray = count_gray_q;
  assign tx_tvalid  = tx_tvalid_q;
  assign tx_tdata   = tx_tdata_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_logic_basic_gray_counter.sv
// Scoreboard bench for logic_basic_gray_counter with a behavioural model;
// Gray codes come from a reflected-sequence table built at start-up.
module tb_logic_basic_gray_counter;

  localparam int W  = 4;
  localparam int M  = 1 << W;
  localparam int RV = 0;
`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
  localparam bit HAS_DOWN = 1'b1;
`else
  localparam bit HAS_DOWN = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         areset_n = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         rx_tvalid = 1'b0;
  logic         rx_tready;
  logic         tx_tvalid;
  logic         tx_tready = 1'b0;
  logic [W-1:0] tx_tdata;
  logic [W-1:0] count;
  logic [W-1:0] count_gray;
  logic         wrap;
`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
  logic         dir = 1'b0;
`endif

  always #5 aclk = ~aclk;

  logic_basic_gray_counter #(.WIDTH(W), .RESET_VALUE(W'(RV))) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .rx_tvalid  (rx_tvalid),
    .rx_tready  (rx_tready),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .tx_tdata   (tx_tdata),
    .count      (count),
    .count_gray (count_gray),
    .wrap       (wrap)
`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
    ,
    .dir        (dir)
`endif
  );

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] cgray;
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         wrap;
  } snap_t;

  typedef struct {
    logic [W-1:0] data;
    bit           disc;
  } beat_t;

  snap_t        state_q[$];
  beat_t        beat_q[$];
  logic [W-1:0] gray_tab[M];

  int           n_checks = 0;
  int           n_pass = 0;
  int           wrap_seen = 0;

  int           m_cnt = RV;
  bit           m_pend = 1'b0;
  logic [W-1:0] m_tdata = '0;
  bit           m_wrap = 1'b0;
  bit           m_disc = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic cycle(input bit rn, input bit c, input bit l, input int lv,
                       input bit v, input bit r, input bit d);
    bit    acc;
    int    old;
    snap_t s;
    beat_t b;
    @(negedge aclk);
    areset_n   = rn;
    clear      = c;
    load       = l;
    load_value = W'(lv);
    rx_tvalid  = v;
    tx_tready  = r;
`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
    dir        = d;
`endif
    #1;
    chk("rx_tready", rx_tready, (rn && !c && !l && (!m_pend || r)));
    #1;
    m_wrap = 1'b0;
    if ((!rn || c) && m_pend && !r) void'(beat_q.pop_back());
    if (!rn) begin
      m_cnt = RV; m_pend = 1'b0; m_tdata = '0; m_disc = 1'b1;
    end else if (c) begin
      m_cnt = RV; m_pend = 1'b0; m_disc = 1'b1;
    end else begin
      acc = v && !l && (!m_pend || r);
      if (m_pend && r) m_pend = 1'b0;
      if (l) begin
        m_cnt = lv % M; m_disc = 1'b1;
      end else if (acc) begin
        old     = m_cnt;
        m_cnt   = d ? (m_cnt + M - 1) % M : (m_cnt + 1) % M;
        m_wrap  = d ? (old == 0) : (old == M - 1);
        m_pend  = 1'b1;
        m_tdata = gray_tab[m_cnt];
        b.data  = m_tdata;
        b.disc  = m_disc;
        m_disc  = 1'b0;
        beat_q.push_back(b);
      end
    end
    @(posedge aclk);
    #1;
    s.cnt    = W'(m_cnt);
    s.cgray  = gray_tab[m_cnt];
    s.tdata  = m_tdata;
    s.tvalid = m_pend;
    s.wrap   = m_wrap;
    state_q.push_back(s);
  endtask

  // Monitor: per-cycle state scoreboard plus the tx beat stream.
  initial begin
    snap_t        s;
    beat_t        e;
    logic [W-1:0] prev = '0;
    bit           have_prev = 1'b0;
    forever begin
      @(negedge aclk);
      #1;
      if (state_q.size() > 0) begin
        s = state_q.pop_front();
        chk("count", count, s.cnt);
        chk("count_gray", count_gray, s.cgray);
        chk("tx_tvalid", tx_tvalid, s.tvalid);
        chk("tx_tdata", tx_tdata, s.tdata);
        chk("wrap", wrap, s.wrap);
        if (wrap === 1'b1) wrap_seen++;
      end
      if (tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
        if (beat_q.size() == 0) begin
          chk("beat_underflow", beat_q.size(), 1);
        end else begin
          e = beat_q.pop_front();
          chk("tx_beat", tx_tdata, e.data);
          if (have_prev && !e.disc) chk("one_bit_change", $countones(tx_tdata ^ prev), 1);
          prev      = tx_tdata;
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    int w0;
    gray_tab[0] = '0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | W'(1 << k);

    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    chk("rst_count", count, RV);
    chk("rst_tx_tvalid", tx_tvalid, 0);

    // Full lap with a ready consumer.
    w0 = wrap_seen;
    for (int i = 0; i < M; i++) begin
      cycle(1, 0, 0, 0, 1, 1, 0);
      if (i == 0) chk("first_beat", tx_tdata, 4'b0001);
      if (i == 1) chk("second_beat", tx_tdata, 4'b0011);
    end
    chk("lap_count", count, 0);
    chk("lap_tdata", tx_tdata, 4'b0000);
    chk("lap_wrap", wrap, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    chk("lap_wrap_once", wrap_seen - w0, 1);

    // Backpressure hold then release.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 0, 0);
    chk("hold_tdata", tx_tdata, 4'b0001);
    chk("hold_count", count, 1);
    cycle(1, 0, 0, 0, 1, 1, 0);
    chk("release_1", tx_tdata, 4'b0011);
    cycle(1, 0, 0, 0, 1, 1, 0);
    chk("release_2", tx_tdata, 4'b0010);

    // Load with a pending beat.
    cycle(1, 0, 1, 7, 1, 0, 0);
    chk("load_count", count, 4'b0111);
    chk("load_gray", count_gray, 4'b0100);
    chk("load_keeps_beat", tx_tdata, 4'b0010);
    chk("load_keeps_valid", tx_tvalid, 1);
    cycle(1, 0, 0, 0, 1, 1, 0);
    chk("post_load_beat", tx_tdata, 4'b1100);

    // Clear beats load and rx with a beat pending.
    cycle(1, 1, 1, 5, 1, 0, 0);
    chk("clear_count", count, RV);
    chk("clear_tvalid", tx_tvalid, 0);
    chk("clear_wrap", wrap, 0);

    // Reset mid-stream at count 1010.
    cycle(1, 0, 1, 9, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_count", count, 4'b1010);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("mid_rst_count", count, RV);
    chk("mid_rst_gray", count_gray, 0);
    chk("mid_rst_tvalid", tx_tvalid, 0);
    chk("mid_rst_tdata", tx_tdata, 0);

`ifdef LOGIC_BASIC_GRAY_COUNTER_DOWN_EN
    cycle(1, 0, 0, 0, 1, 1, 1);
    chk("down_from_zero", tx_tdata, 4'b1000);
    chk("down_wrap", wrap, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(63) != 0, $urandom_range(31) == 0, $urandom_range(31) == 0,
            int'($urandom_range(M - 1)), $urandom_range(3) != 0, $urandom_range(3) != 0,
            HAS_DOWN ? 1'($urandom_range(1)) : 1'b0);
    end

    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    @(negedge aclk);
    #3;
    chk("beats_left", beat_q.size(), m_pend);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
